led_sequencer: RTL

Pattern stage sitting directly downstream of the clock divider. It consumes the divider's one-cycle `tick` pulse, which is a clock enable in the `clk` domain, and drives the board LEDs with one of four selectable patterns: off, blink, chase, or breathe. Breathe is a PWM duty ramp. All state advances only on `tick`. The PWM counter runs at full `clk` rate.

---
 rtl/led_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// LED pattern stage: off / blink / chase / breathe, advanced by the divider's tick strobe.
// Define LED_SEQ_BREATHE_EN to build the PWM breathe mode; otherwise mode 3 decodes as BLINK.
module led_sequencer #(
  parameter int LED_W        = 2,
  parameter int PWM_BITS     = 8,
  parameter int BREATHE_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic [1:0]       cur_mode
);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLINK = 2'd1;
  localparam logic [1:0] S_CHASE = 2'd2;
`ifdef LED_SEQ_BREATHE_EN
  localparam logic [1:0]          S_BREATHE = 2'd3;
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS:0]   STEP      = (PWM_BITS+1)'(BREATHE_STEP);
`endif

  // tick is a one-cycle strobe with no back-pressure; it only counts when enable is
  // also high on the same edge, so a tick landing while enable is low is dropped.
  logic             adv;
  logic [1:0]       state, state_d, mode_dec;
  logic [LED_W-1:0] pat, pat_d, led_d;
  logic [PWM_BITS-1:0] pwm_cnt;
`ifdef LED_SEQ_BREATHE_EN
  logic [PWM_BITS-1:0] duty, duty_d;
  logic                down, down_d;
  logic [PWM_BITS:0]   sum;
`endif

  assign adv      = tick & enable;
  assign cur_mode = state;

  always_comb begin
`ifdef LED_SEQ_BREATHE_EN
    mode_dec = mode;
`else
    mode_dec = (mode == 2'd3) ? S_BLINK : mode;
`endif
  end

  always_comb begin
    state_d = state;
    pat_d   = pat;
`ifdef LED_SEQ_BREATHE_EN
    duty_d  = duty;
    down_d  = down;
    sum     = {1'b0, duty} + STEP;
`endif
    if (adv) begin
      if (mode_dec != state) begin
        // Mode entry loads the entry pattern without advancing it.
        state_d = mode_dec;
        case (mode_dec)
          S_BLINK: pat_d = '1;
          S_CHASE: pat_d = LED_W'(1);
`ifdef LED_SEQ_BREATHE_EN
          S_BREATHE: begin
            duty_d = '0;
            down_d = 1'b0;
          end
`endif
          default: pat_d = '0;
        endcase
      end else begin
        case (state)
          S_BLINK: pat_d = ~pat;
          S_CHASE: pat_d = (pat << 1) | (pat >> (LED_W - 1));
`ifdef LED_SEQ_BREATHE_EN
          S_BREATHE: begin
            if (!down) begin
              if (sum >= {1'b0, MAX}) begin
                duty_d = MAX;
                down_d = 1'b1;
              end else begin
                duty_d = sum[PWM_BITS-1:0];
              end
            end else if ({1'b0, duty} <= STEP) begin
              duty_d = '0;
              down_d = 1'b0;
            end else begin
              duty_d = duty - STEP[PWM_BITS-1:0];
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Breathe compares against the registered duty, so a new duty shows one cycle late.
  always_comb begin
    led_d = '0;
    if (enable) begin
      case (state_d)
        S_BLINK, S_CHASE: led_d = pat_d;
`ifdef LED_SEQ_BREATHE_EN
        S_BREATHE: led_d = {LED_W{pwm_cnt < duty}};
`endif
        default: led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_OFF;
      pat     <= '0;
      led     <= '0;
      pwm_cnt <= '0;
`ifdef LED_SEQ_BREATHE_EN
      duty    <= '0;
      down    <= 1'b0;
`endif
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= led_d;
      if (enable) begin
        state <= state_d;
        pat   <= pat_d;
`ifdef LED_SEQ_BREATHE_EN
        duty  <= duty_d;
        down  <= down_d;
`endif
      end
    end
  end

endmodule
